// File: rtl/i2c_target_port.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// byte-level write receive and read return through a tx_req/rx_valid handshake. Open-drain SDA.
`timescale 1ns/1ps
module i2c_target_port #(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] bit_cnt, bit_cnt_n, cnt_m1;
  logic [7:0] shreg, shreg_n, shift_in, tx_shift, tx_shift_n, rx_data_n;
  logic       rw, rw_n, ack_flag, ack_n, drive_low, drive_n, busy_n;
  logic       rx_valid_n, tx_req_n, addr_hit_n;

  assign sda = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign shift_in  = {shreg[6:0], sda_s};
  assign cnt_m1    = bit_cnt - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      shreg     <= '0;
      tx_shift  <= '0;
      rw        <= 1'b0;
      ack_flag  <= 1'b0;
      drive_low <= 1'b0;
      rx_data   <= '0;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addr_hit  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      tx_shift  <= tx_shift_n;
      rw        <= rw_n;
      ack_flag  <= ack_n;
      drive_low <= drive_n;
      rx_data   <= rx_data_n;
      busy      <= busy_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      addr_hit  <= addr_hit_n;
    end
  end

  // ack_flag marks the second half of a two-fall ACK slot (drive on first fall, leave on second).
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_shift_n = tx_shift;
    rw_n       = rw;
    ack_n      = ack_flag;
    drive_n    = drive_low;
    rx_data_n  = rx_data;
    busy_n     = busy;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    addr_hit_n = 1'b0;

    case (state)
      ADDR_S: if (scl_rise) begin
        shreg_n = shift_in;
        if (bit_cnt == 3'd0) begin
          if (shift_in[7:1] == ADDR) begin
            state_n    = ADDR_ACK;
            addr_hit_n = 1'b1;
            busy_n     = 1'b1;
            rw_n       = sda_s;
            ack_n      = 1'b0;
          end else begin
            state_n = WAIT_STOP;
          end
        end else begin
          bit_cnt_n = cnt_m1;
        end
      end
      ADDR_ACK: if (scl_fall) begin
        if (!ack_flag) begin
          drive_n = 1'b1;
          ack_n   = 1'b1;
        end else if (!rw) begin
          drive_n   = 1'b0;
          bit_cnt_n = 3'd7;
          state_n   = WRITE;
        end else begin
          tx_shift_n = tx_data;
          tx_req_n   = 1'b1;
          drive_n    = ~tx_data[7];
          bit_cnt_n  = 3'd7;
          state_n    = READ;
        end
      end
      WRITE: if (scl_rise) begin
        shreg_n = shift_in;
        if (bit_cnt == 3'd0) begin
          state_n = WRITE_ACK;
          ack_n   = 1'b0;
        end else begin
          bit_cnt_n = cnt_m1;
        end
      end
      WRITE_ACK: if (scl_fall) begin
        if (!ack_flag) begin
          drive_n    = 1'b1;
          rx_data_n  = shreg;
          rx_valid_n = 1'b1;
          ack_n      = 1'b1;
        end else begin
          drive_n   = 1'b0;
          bit_cnt_n = 3'd7;
          state_n   = WRITE;
        end
      end
      READ: if (scl_fall) begin
        if (bit_cnt == 3'd0) begin
          drive_n = 1'b0;
          ack_n   = 1'b0;
          state_n = READ_ACK;
        end else begin
          bit_cnt_n = cnt_m1;
          drive_n   = ~tx_shift[cnt_m1];
        end
      end
      READ_ACK: begin
        if (scl_rise) begin
          if (!sda_s) ack_n = 1'b1;
          else        state_n = WAIT_STOP;
        end else if (scl_fall && ack_flag) begin
          tx_shift_n = tx_data;
          tx_req_n   = 1'b1;
          drive_n    = ~tx_data[7];
          bit_cnt_n  = 3'd7;
          ack_n      = 1'b0;
          state_n    = READ;
        end
      end
      WAIT_STOP: drive_n = 1'b0;
      default: ;
    endcase

    // Bus conditions override any bit-level action taken in the same cycle.
    if (start_det) begin
      state_n    = ADDR_S;
      bit_cnt_n  = 3'd7;
      drive_n    = 1'b0;
      busy_n     = 1'b0;
      ack_n      = 1'b0;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      addr_hit_n = 1'b0;
    end else if (stop_det) begin
      state_n    = IDLE;
      drive_n    = 1'b0;
      busy_n     = 1'b0;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      addr_hit_n = 1'b0;
    end
  end

endmodule
